keypad_scanner: RTL

- Scans a 4x4 matrix keypad (Pmod KYPD) on the Basys3 PMOD header.
- Drives one column low at a time and reads the rows back. This is the input-side counterpart of the multiplexed seven-segment scan, which drives segment and anode lines.
- Debounces and decodes a single pressed key into a 4-bit hex code plus a one-cycle valid pulse.
- Runs on the 100 MHz board clock and feeds the clock/stopwatch control logic as a time-entry source.

---
 rtl/keypad_scanner.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, samples the rows,
// and debounces single-key presses and releases over whole-matrix scans.
//
// state     | meaning
// IDLE      | no key registered, waiting for a single-key scan
// DEB_PRESS | same single key seen on consecutive scans, counting toward a press
// PRESSED   | key registered; rollover and extra keys are ignored
// DEB_REL   | empty scans seen, counting toward a release
module keypad_scanner #(
    parameter int SCAN_CYCLES    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int             DW         = $clog2(SCAN_CYCLES);
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [3:0]     DEB_LAST   = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} state_t;

    logic [3:0]    row_s1_q, row_s2_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [15:0]   image_q, image_d;
    state_t        state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          capture, scan_done, press_done;
    logic [4:0]    n_keys;
    logic [3:0]    hit_idx;
    logic [3:0]    hit_code;
    logic          is_none, is_single;

    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = 4'h0;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'h0;
            4'b11_01: code = 4'hF;
            4'b11_10: code = 4'hE;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
        end
    end

    assign capture   = (dwell_q == DWELL_LAST);
    assign scan_done = capture && (col_idx_q == 2'd3);
    assign col       = ~(4'b0001 << col_idx_q);

    // Image bit c*4+r is 1 when key (r,c) is pressed; the current slice is
    // folded in here so the classifier sees the complete scan on its last capture.
    always_comb begin
        image_d   = image_q;
        dwell_d   = dwell_q + 1'b1;
        col_idx_d = col_idx_q;
        if (capture) begin
            image_d[{col_idx_q, 2'b00} +: 4] = ~row_s2_q;
            dwell_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_q   <= '0;
            col_idx_q <= 2'd0;
            image_q   <= '0;
        end else begin
            dwell_q   <= dwell_d;
            col_idx_q <= col_idx_d;
            image_q   <= image_d;
        end
    end

    always_comb begin
        n_keys  = '0;
        hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            n_keys = n_keys + 5'(image_d[i]);
            if (image_d[i]) hit_idx = 4'(i);
        end
        hit_code  = key_map(hit_idx[1:0], hit_idx[3:2]);
        is_none   = (n_keys == 5'd0);
        is_single = (n_keys == 5'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cand_q      <= '0;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_valid_q <= press_done;
            if (press_done) key_code_q <= cand_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        press_done = 1'b0;
        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (is_single) begin
                        cand_d = hit_code;
                        cnt_d  = 4'd1;
                        if (DEB_LAST == 4'd1) begin
                            state_d    = PRESSED;
                            press_done = 1'b1;
                        end else begin
                            state_d = DEB_PRESS;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (!is_single) begin
                        state_d = IDLE;
                    end else begin
                        if (hit_code == cand_q) begin
                            cnt_d = cnt_q + 4'd1;
                        end else begin
                            cand_d = hit_code;
                            cnt_d  = 4'd1;
                        end
                        if (cnt_d == DEB_LAST) begin
                            state_d    = PRESSED;
                            press_done = 1'b1;
                        end
                    end
                end
                PRESSED: begin
                    if (is_none) begin
                        cnt_d   = 4'd1;
                        state_d = (DEB_LAST == 4'd1) ? IDLE : DEB_REL;
                    end
                end
                default: begin
                    if (is_none) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == DEB_LAST) state_d = IDLE;
                    end else begin
                        state_d = PRESSED;
                    end
                end
            endcase
        end
    end

    always_comb begin
        key_held  = (state_q == PRESSED) || (state_q == DEB_REL);
        key_code  = key_code_q;
        key_valid = key_valid_q;
    end

endmodule
